// File: rtl/writeback_arbiter_if.sv
// ============================================================================
//  Module      : writeback_arbiter_if
//  Description : Bundle of the ALU result, load result and register-file write
//                signals around the writeback arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface writeback_arbiter_if #(
  parameter int XLEN = 64
);
  logic            alu_valid;
  logic [4:0]      alu_rd;
  logic [XLEN-1:0] alu_data;
  logic            ld_valid;
  logic [4:0]      ld_rd;
  logic [XLEN-1:0] ld_data;
  logic            ld_ready;
  logic            stall_alu;
  logic            reg_write;
  logic [4:0]      write_reg;
  logic [XLEN-1:0] write_data;
  logic [1:0]      pending;

  // Pipeline side: produces results, observes the register-file write.
  modport master (
    output alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_data,
    input  ld_ready, stall_alu, reg_write, write_reg, write_data, pending
  );

  // Arbiter side.
  modport slave (
    input  alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_data,
    output ld_ready, stall_alu, reg_write, write_reg, write_data, pending
  );
endinterface

`default_nettype wire

// File: rtl/writeback_arbiter.sv
// ============================================================================
//  Module      : writeback_arbiter
//  Description : Merges ALU and load results onto one register-file write
//                port. ALU results win; loads are buffered in a 2-entry FIFO
//                and written in acceptance order.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module writeback_arbiter #(
  parameter int XLEN  = 64,
  parameter int DEPTH = 2    // queue logic assumes exactly two entries
) (
  input  logic               clk,
  input  logic               reset_n,
  writeback_arbiter_if.slave bus
);

  localparam logic [1:0] C_FULL = 2'd2;

  // Queue state: 1-bit pointers wrap naturally over the two entries.
  logic [1:0]      r_pending;
  logic            r_wr_ptr;
  logic            r_rd_ptr;
  logic [4:0]      r_q_rd   [DEPTH];
  logic [XLEN-1:0] r_q_data [DEPTH];

  // Registered write port.
  logic            r_reg_write;
  logic [4:0]      r_write_reg;
  logic [XLEN-1:0] r_write_data;

  logic            w_ld_ready;
  logic            w_alu_live;
  logic            w_ld_live;
  logic            w_q_empty;
  logic            w_pop;
  logic            w_bypass;
  logic            w_push;
  logic [1:0]      w_pending_next;
  logic            w_sel_valid;
  logic [4:0]      w_sel_rd;
  logic [XLEN-1:0] w_sel_data;

  // Readiness comes only from the registered count, so there is no
  // combinational path from ld_valid back to ld_ready.
  assign w_ld_ready = (r_pending < C_FULL);
  assign w_q_empty  = (r_pending == 2'd0);

  // Writes to x0 are meaningless: such ALU results are ignored and such
  // loads are accepted but dropped.
  assign w_alu_live = bus.alu_valid && (bus.alu_rd != 5'd0);
  assign w_ld_live  = bus.ld_valid && w_ld_ready && (bus.ld_rd != 5'd0);

  // ALU first, then queue head, then a load straight through an empty queue.
  assign w_pop    = !w_alu_live && !w_q_empty;
  assign w_bypass = !w_alu_live && w_q_empty && w_ld_live;
  assign w_push   = w_ld_live && !w_bypass;

  // Select the source for next cycle's register-file write.
  always_comb begin
    w_sel_valid = 1'b0;
    w_sel_rd    = r_write_reg;
    w_sel_data  = r_write_data;
    if (w_alu_live) begin
      w_sel_valid = 1'b1;
      w_sel_rd    = bus.alu_rd;
      w_sel_data  = bus.alu_data;
    end else if (w_pop) begin
      w_sel_valid = 1'b1;
      w_sel_rd    = r_q_rd[r_rd_ptr];
      w_sel_data  = r_q_data[r_rd_ptr];
    end else if (w_bypass) begin
      w_sel_valid = 1'b1;
      w_sel_rd    = bus.ld_rd;
      w_sel_data  = bus.ld_data;
    end
  end

  // Occupancy update; simultaneous push and pop leaves it unchanged.
  always_comb begin
    w_pending_next = r_pending;
    case ({w_push, w_pop})
      2'b10:   w_pending_next = r_pending + 2'd1;
      2'b01:   w_pending_next = r_pending - 2'd1;
      default: w_pending_next = r_pending;
    endcase
  end

  // Control state and write port; reset also cancels any scheduled write.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pending    <= 2'd0;
      r_wr_ptr     <= 1'b0;
      r_rd_ptr     <= 1'b0;
      r_reg_write  <= 1'b0;
      r_write_reg  <= 5'd0;
      r_write_data <= '0;
    end else begin
      r_pending   <= w_pending_next;
      r_reg_write <= w_sel_valid;
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_sel_valid) begin
        r_write_reg  <= w_sel_rd;
        r_write_data <= w_sel_data;
      end
    end
  end

  // Queue payload storage; contents are only meaningful below r_pending.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q_rd[r_wr_ptr]   <= bus.ld_rd;
      r_q_data[r_wr_ptr] <= bus.ld_data;
    end
  end

  assign bus.ld_ready   = w_ld_ready;
  assign bus.stall_alu  = (r_pending == C_FULL);
  assign bus.reg_write  = r_reg_write;
  assign bus.write_reg  = r_write_reg;
  assign bus.write_data = r_write_data;
  assign bus.pending    = r_pending;

endmodule

`default_nettype wire

// File: tb/tb_writeback_arbiter.sv
// ============================================================================
//  Module      : tb_writeback_arbiter
//  Description : Directed self-checking bench for writeback_arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_writeback_arbiter;

  localparam int XLEN = 64;

  logic clk;
  logic reset_n;
  int   n_vec;
  int   n_err;

  writeback_arbiter_if #(.XLEN(XLEN)) bus ();

  writeback_arbiter #(.XLEN(XLEN), .DEPTH(2)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic av, input logic [4:0] ard, input logic [63:0] ad,
                       input logic lv, input logic [4:0] lrd, input logic [63:0] ld);
    bus.alu_valid = av;
    bus.alu_rd    = ard;
    bus.alu_data  = ad;
    bus.ld_valid  = lv;
    bus.ld_rd     = lrd;
    bus.ld_data   = ld;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 64'h0);
  endtask

  task automatic chk_wr(input string tag, input logic rw, input logic [4:0] rd,
                        input logic [63:0] d, input logic [1:0] pend);
    chk({tag, ".reg_write"},  {63'h0, bus.reg_write}, {63'h0, rw});
    chk({tag, ".write_reg"},  {59'h0, bus.write_reg}, {59'h0, rd});
    chk({tag, ".write_data"}, bus.write_data, d);
    chk({tag, ".pending"},    {62'h0, bus.pending}, {62'h0, pend});
  endtask

  task automatic chk_flow(input string tag, input logic rdy, input logic stl);
    chk({tag, ".ld_ready"},  {63'h0, bus.ld_ready},  {63'h0, rdy});
    chk({tag, ".stall_alu"}, {63'h0, bus.stall_alu}, {63'h0, stl});
  endtask

  initial begin
    n_vec   = 0;
    n_err   = 0;
    reset_n = 1'b0;
    idle();

    // Reset state
    step();
    step();
    chk_wr("rst", 1'b0, 5'd0, 64'h0, 2'd0);
    chk_flow("rst", 1'b1, 1'b0);
    reset_n = 1'b1;

    // ALU only
    drive(1'b1, 5'd5, 64'h11, 1'b0, 5'd0, 64'h0);
    step();
    chk_wr("alu", 1'b1, 5'd5, 64'h11, 2'd0);
    idle();
    step();
    chk_wr("alu_idle", 1'b0, 5'd5, 64'h11, 2'd0);

    // Load bypass through empty queue
    drive(1'b0, 5'd0, 64'h0, 1'b1, 5'd7, 64'hAA);
    chk_flow("byp_pre", 1'b1, 1'b0);
    step();
    chk_wr("byp", 1'b1, 5'd7, 64'hAA, 2'd0);

    // ALU busy while loads x1,x2,x3 are offered
    drive(1'b1, 5'd10, 64'h100, 1'b1, 5'd1, 64'hA1);
    step();
    chk_wr("q_a", 1'b1, 5'd10, 64'h100, 2'd1);
    drive(1'b1, 5'd11, 64'h101, 1'b1, 5'd2, 64'hA2);
    step();
    chk_wr("q_b", 1'b1, 5'd11, 64'h101, 2'd2);
    chk_flow("q_b", 1'b0, 1'b1);
    drive(1'b1, 5'd12, 64'h102, 1'b1, 5'd3, 64'hA3);
    step();
    chk_wr("q_c", 1'b1, 5'd12, 64'h102, 2'd2);
    chk_flow("q_c", 1'b0, 1'b1);
    drive(1'b0, 5'd0, 64'h0, 1'b1, 5'd3, 64'hA3);
    step();
    chk_wr("q_d", 1'b1, 5'd1, 64'hA1, 2'd1);
    chk_flow("q_d", 1'b1, 1'b0);
    // Head popped while x3 pushed: pending stays 1
    step();
    chk_wr("q_e", 1'b1, 5'd2, 64'hA2, 2'd1);
    idle();
    step();
    chk_wr("q_f", 1'b1, 5'd3, 64'hA3, 2'd0);
    step();
    chk_wr("q_g", 1'b0, 5'd3, 64'hA3, 2'd0);

    // x0 ALU and x0 load with one entry queued
    drive(1'b1, 5'd9, 64'h9, 1'b1, 5'd4, 64'h44);
    step();
    chk_wr("z_a", 1'b1, 5'd9, 64'h9, 2'd1);
    drive(1'b1, 5'd0, 64'hDEAD, 1'b1, 5'd0, 64'hBEEF);
    step();
    chk_wr("z_b", 1'b1, 5'd4, 64'h44, 2'd0);
    idle();
    step();
    chk_wr("z_c", 1'b0, 5'd4, 64'h44, 2'd0);

    // Asynchronous reset with a full queue
    drive(1'b1, 5'd20, 64'h200, 1'b1, 5'd5, 64'h55);
    step();
    drive(1'b1, 5'd21, 64'h201, 1'b1, 5'd6, 64'h66);
    step();
    chk_wr("r_full", 1'b1, 5'd21, 64'h201, 2'd2);
    idle();
    #2;
    reset_n = 1'b0;
    #1;
    chk_wr("r_async", 1'b0, 5'd0, 64'h0, 2'd0);
    chk_flow("r_async", 1'b1, 1'b0);
    step();
    #3;
    reset_n = 1'b1;
    step();
    chk_wr("r_post1", 1'b0, 5'd0, 64'h0, 2'd0);
    step();
    chk_wr("r_post2", 1'b0, 5'd0, 64'h0, 2'd0);
    chk_flow("r_post2", 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
